// File: rtl/fe_tx_framer.sv
// fe_tx_framer
//   Builds one host-link frame per accepted start and streams it to a UART TX
//   byte port with a valid/ready handshake:
//     CNT[15:8], CNT[7:0], CMD, then a tail chosen by the latched command.
//   The tail is empty for CMD_END and four SEC bytes (MSB first) for CMD_SEC.
//   Any other command appends cnt payload bytes popped from a FWFT FIFO.
//   tx_data/tx_valid/busy/done are registered; pl_rd is combinational so the
//   pop lands on the same edge that loads the popped byte into tx_data.
module fe_tx_framer #(
  parameter logic [7:0] CMD_END = 8'h03,
  parameter logic [7:0] CMD_SEC = 8'h05
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  cmd,
  input  logic [15:0] cnt,
  input  logic [31:0] sec,
  input  logic [7:0]  pl_data,
  input  logic        pl_empty,
  output logic        pl_rd,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_SEC  = 3'd2,
    ST_PAY  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t      state_r, state_nx_s;
  logic [7:0]  cmd_r, cmd_nx_s;
  logic [15:0] cnt_r, cnt_nx_s;
  logic [31:0] sec_r, sec_nx_s;
  logic [1:0]  idx_r, idx_nx_s;
  logic [15:0] rem_r, rem_nx_s;
  logic [7:0]  tx_data_r, tx_data_nx_s;
  logic        tx_valid_r, tx_valid_nx_s;
  logic        busy_r, busy_nx_s;
  logic        done_r, done_nx_s;

  logic        hs_s;
  logic        slot_free_s;
  logic        pl_rd_s;

  // Handshake, free output slot and payload pop qualification.
  always_comb begin
    hs_s        = tx_valid_r & tx_ready;
    slot_free_s = ~tx_valid_r | tx_ready;
    pl_rd_s     = (state_r == ST_PAY) & (rem_r != 16'd0) & ~pl_empty & slot_free_s;
  end

  // Next-state and next-datapath values; every register holds unless told otherwise.
  always_comb begin
    state_nx_s    = state_r;
    cmd_nx_s      = cmd_r;
    cnt_nx_s      = cnt_r;
    sec_nx_s      = sec_r;
    idx_nx_s      = idx_r;
    rem_nx_s      = rem_r;
    tx_data_nx_s  = tx_data_r;
    tx_valid_nx_s = tx_valid_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          cmd_nx_s      = cmd;
          cnt_nx_s      = cnt;
          sec_nx_s      = sec;
          tx_data_nx_s  = cnt[15:8];
          tx_valid_nx_s = 1'b1;
          idx_nx_s      = 2'd0;
          state_nx_s    = ST_HDR;
        end else begin
          tx_valid_nx_s = 1'b0;
        end
      end
      ST_HDR: begin
        if (hs_s) begin
          if (idx_r == 2'd0) begin
            tx_data_nx_s = cnt_r[7:0];
            idx_nx_s     = 2'd1;
          end else if (idx_r == 2'd1) begin
            tx_data_nx_s = cmd_r;
            idx_nx_s     = 2'd2;
          end else if (cmd_r == CMD_END) begin
            tx_valid_nx_s = 1'b0;
            state_nx_s    = ST_DONE;
          end else if (cmd_r == CMD_SEC) begin
            // Present the top sector byte now and pre-shift so the next one sits on top.
            tx_data_nx_s = sec_r[31:24];
            sec_nx_s     = {sec_r[23:0], 8'h00};
            idx_nx_s     = 2'd0;
            state_nx_s   = ST_SEC;
          end else if (cnt_r == 16'd0) begin
            tx_valid_nx_s = 1'b0;
            state_nx_s    = ST_DONE;
          end else begin
            tx_valid_nx_s = 1'b0;
            rem_nx_s      = cnt_r;
            state_nx_s    = ST_PAY;
          end
        end else begin
          state_nx_s = ST_HDR;
        end
      end
      ST_SEC: begin
        if (hs_s) begin
          if (idx_r == 2'd3) begin
            tx_valid_nx_s = 1'b0;
            state_nx_s    = ST_DONE;
          end else begin
            tx_data_nx_s = sec_r[31:24];
            sec_nx_s     = {sec_r[23:0], 8'h00};
            idx_nx_s     = idx_r + 2'd1;
          end
        end else begin
          state_nx_s = ST_SEC;
        end
      end
      ST_PAY: begin
        if (pl_rd_s) begin
          tx_data_nx_s  = pl_data;
          tx_valid_nx_s = 1'b1;
          rem_nx_s      = rem_r - 16'd1;
        end else if ((rem_r == 16'd0) && hs_s) begin
          tx_valid_nx_s = 1'b0;
          state_nx_s    = ST_DONE;
        end else if (slot_free_s) begin
          // FIFO ran dry with the slot free: drop valid and wait for data.
          tx_valid_nx_s = 1'b0;
        end else begin
          tx_valid_nx_s = tx_valid_r;
        end
      end
      ST_DONE: begin
        tx_valid_nx_s = 1'b0;
        state_nx_s    = ST_IDLE;
      end
      default: begin
        tx_valid_nx_s = 1'b0;
        state_nx_s    = ST_IDLE;
      end
    endcase
    busy_nx_s = (state_nx_s == ST_HDR) || (state_nx_s == ST_SEC) || (state_nx_s == ST_PAY);
    done_nx_s = (state_nx_s == ST_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cmd_r      <= 8'h00;
      cnt_r      <= 16'h0000;
      sec_r      <= 32'h0000_0000;
      idx_r      <= 2'd0;
      rem_r      <= 16'h0000;
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      cmd_r      <= cmd_nx_s;
      cnt_r      <= cnt_nx_s;
      sec_r      <= sec_nx_s;
      idx_r      <= idx_nx_s;
      rem_r      <= rem_nx_s;
      tx_data_r  <= tx_data_nx_s;
      tx_valid_r <= tx_valid_nx_s;
      busy_r     <= busy_nx_s;
      done_r     <= done_nx_s;
    end
  end

  assign pl_rd    = pl_rd_s;
  assign tx_data  = tx_data_r;
  assign tx_valid = tx_valid_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule
